iob_dbus_split: RTL and testbench

Address-decoding request splitter placed directly downstream of the CPU core wrapper's data bus. It routes one IOb native master request to one of N_SLAVES slave ports, selected by the top address bits, and returns the selected slave's response. It also provides a response watchdog and an unmapped-address responder, so a dead or missing slave can never hang the core. Sticky error status is exported for software or debug inspection.

---
 rtl/iob_dbus_split_pkg.sv | 40 ++++
 rtl/iob_dbus_split_watchdog.sv | 29 ++
 rtl/iob_dbus_split.sv | 192 +++++++++++++++++++
 tb/tb_iob_dbus_split.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_dbus_split_pkg.sv
// Shared definitions for the IOb data-bus splitter: FSM encoding, counter width
// and the bit layout of the packed request {valid, addr, wdata, wstrb} and response {rdata, ready}.
package iob_dbus_split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_UNMAP = 2'd2
    } split_state_t;

    localparam int CNT_W          = 16;
    localparam int RESP_READY_BIT = 0;
    localparam int RESP_RDATA_LSB = 1;
    localparam int REQ_WSTRB_LSB  = 0;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int req_wdata_lsb(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int req_addr_lsb(input int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int req_valid_bit(input int addr_w, input int data_w);
        return addr_w + data_w + data_w / 8;
    endfunction

endpackage

// File: rtl/iob_dbus_split_watchdog.sv
// Response watchdog: counts cycles spent waiting on a slave and flags when the
// count reaches TIMEOUT. Firing at equality keeps the 16-bit counter from wrapping.
module iob_split_watchdog
    import iob_dbus_split_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/iob_dbus_split.sv
// Routes one IOb master request to a slave chosen by the top address bits, with a
// response watchdog, an unmapped-address responder and sticky error capture.
module iob_dbus_split
    import iob_dbus_split_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 N_SLAVES = 4,
    parameter int                 TIMEOUT  = 255,
    parameter logic [DATA_W-1:0]  ERR_DATA = 32'hDEADBEEF,
    localparam int                REQ_W    = req_w(ADDR_W, DATA_W),
    localparam int                RESP_W   = resp_w(DATA_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_W-1:0]           m_req,
    output logic [RESP_W-1:0]          m_resp,
    output logic [N_SLAVES*REQ_W-1:0]  s_req,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp,
    input  logic                       err_clr,
    output logic                       err_flag,
    output logic                       err_timeout,
    output logic [ADDR_W-1:0]          err_addr
);

    localparam int SEL_W     = $clog2(N_SLAVES);
    localparam int VALID_BIT = req_valid_bit(ADDR_W, DATA_W);
    localparam int ADDR_LSB  = req_addr_lsb(DATA_W);

    split_state_t      state;
    logic [SEL_W-1:0]  cur_sel;

    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  route_sel;
    logic              mapped;

    logic [N_SLAVES-1:0] route_oh;
    logic [N_SLAVES-1:0] s_ready;
    logic [DATA_W-1:0]   s_rdata [N_SLAVES];
    logic [N_SLAVES-1:0] s_valid_vec;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;

    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;
    logic              go_wait;
    logic              go_unmap;
    logic              timeout_hit;
    logic              expired;
    logic              wd_inc;

    assign m_valid = m_req[VALID_BIT];
    assign m_addr  = m_req[ADDR_LSB +: ADDR_W];
    assign sel     = m_addr[ADDR_W-1 -: SEL_W];
    assign mapped  = ({1'b0, sel} < (SEL_W+1)'(N_SLAVES));

    // While waiting, the latched selection owns the route, not the live address.
    assign route_sel = (state == ST_WAIT) ? cur_sel : sel;

    for (genvar g = 0; g < N_SLAVES; g++) begin : g_slave
        assign s_req[g*REQ_W +: REQ_W] = {s_valid_vec[g], m_req[REQ_W-2:0]};
        assign s_ready[g]              = s_resp[g*RESP_W + RESP_READY_BIT];
        assign s_rdata[g]              = s_resp[g*RESP_W + RESP_RDATA_LSB +: DATA_W];
    end

    always_comb begin
        route_oh = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            route_oh[i] = mapped_route(route_sel, i);
        end
    end

    function automatic logic mapped_route(input logic [SEL_W-1:0] rs, input int idx);
        return (rs == SEL_W'(idx));
    endfunction

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (route_oh[i]) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[i];
            end
        end
    end

    always_comb begin
        s_valid_vec = '0;
        m_ready     = 1'b0;
        m_rdata     = '0;
        go_wait     = 1'b0;
        go_unmap    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m_valid) begin
                    if (mapped) begin
                        s_valid_vec = route_oh;
                        if (sel_ready) begin
                            m_ready = 1'b1;
                            m_rdata = sel_rdata;
                        end else begin
                            go_wait = 1'b1;
                        end
                    end else begin
                        go_unmap = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                s_valid_vec = route_oh & {N_SLAVES{m_valid}};
                if (sel_ready) begin
                    m_ready = 1'b1;
                    m_rdata = sel_rdata;
                end else if (expired) begin
                    m_ready     = 1'b1;
                    m_rdata     = ERR_DATA;
                    timeout_hit = 1'b1;
                end
            end
            ST_UNMAP: begin
                m_ready = 1'b1;
                m_rdata = ERR_DATA;
            end
            default: ;
        endcase
        // Reset silences the combinational paths at once, abandoning any pending access.
        if (rst) begin
            s_valid_vec = '0;
            m_ready     = 1'b0;
            m_rdata     = '0;
            go_wait     = 1'b0;
            go_unmap    = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    assign m_resp = {m_rdata, m_ready};
    assign wd_inc = (state == ST_WAIT) && !m_ready;

    iob_split_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .load   (go_wait),
        .inc    (wd_inc),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur_sel     <= '0;
            err_flag    <= 1'b0;
            err_timeout <= 1'b0;
            err_addr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go_wait) begin
                        state   <= ST_WAIT;
                        cur_sel <= sel;
                    end else if (go_unmap) begin
                        state <= ST_UNMAP;
                    end
                end
                ST_WAIT: begin
                    if (m_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_UNMAP: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            // A new error outranks a simultaneous clear.
            if (go_unmap || timeout_hit) begin
                err_flag    <= 1'b1;
                err_timeout <= timeout_hit;
                err_addr    <= m_addr;
            end else if (err_clr) begin
                err_flag    <= 1'b0;
                err_timeout <= 1'b0;
                err_addr    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_iob_dbus_split.sv
// Randomized scoreboard bench for iob_dbus_split with three slaves and a short
// watchdog, so sel 3 is unmapped and timeouts are cheap to reach.
module tb_iob_dbus_split;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int STRB_W   = 4;
    localparam int N_SLAVES = 3;
    localparam int SEL_W    = 2;
    localparam int TIMEOUT  = 8;
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int RESP_W   = DATA_W + 1;
    localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       err_clr = 1'b0;
    logic [REQ_W-1:0]           m_req = '0;
    logic [RESP_W-1:0]          m_resp;
    logic [N_SLAVES*REQ_W-1:0]  s_req;
    logic [N_SLAVES*RESP_W-1:0] s_resp = '0;
    logic                       err_flag;
    logic                       err_timeout;
    logic [ADDR_W-1:0]          err_addr;

    iob_dbus_split #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .N_SLAVES(N_SLAVES),
        .TIMEOUT (TIMEOUT),
        .ERR_DATA(ERR_DATA)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_req      (m_req),
        .m_resp     (m_resp),
        .s_req      (s_req),
        .s_resp     (s_resp),
        .err_clr    (err_clr),
        .err_flag   (err_flag),
        .err_timeout(err_timeout),
        .err_addr   (err_addr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "time limit");
    end

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];                 // {ready_cycle, rdata}
    logic [N_SLAVES-1:0] exp_sv = '0;
    logic mon_on = 1'b0;

    logic             ef = 1'b0;
    logic             et = 1'b0;
    logic [ADDR_W-1:0] ea = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic [N_SLAVES-1:0] mon_sv;
    logic [63:0]         mon_e;

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            for (int i = 0; i < N_SLAVES; i++) mon_sv[i] = s_req[i*REQ_W + REQ_W - 1];
            check("s_valid", 64'(mon_sv), 64'(exp_sv));
            for (int i = 0; i < N_SLAVES; i++)
                check("s_fields", 64'(s_req[i*REQ_W +: REQ_W-1]), 64'(m_req[REQ_W-2:0]));
            if (m_resp[0]) begin
                if (exp_q.size() == 0) begin
                    check("ready_when_idle", 64'(m_resp[0]), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rdata", 64'(m_resp[RESP_W-1:1]), 64'(mon_e[31:0]));
                    check("ready_cycle", 64'(cyc), 64'(mon_e[63:32]));
                end
            end else begin
                check("idle_rdata", 64'(m_resp[RESP_W-1:1]), 64'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic check_err();
        check("err_flag", 64'(err_flag), 64'(ef));
        check("err_timeout", 64'(err_timeout), 64'(et));
        check("err_addr", 64'(err_addr), 64'(ea));
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after ready.
    task automatic do_txn(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input logic [STRB_W-1:0] wstrb, input int w,
                          input logic [DATA_W-1:0] rdata, input logic clr);
        int sel, start, lat;
        logic mapped, to, done;
        logic [DATA_W-1:0] exp_rd;
        sel    = int'(addr[ADDR_W-1 -: SEL_W]);
        mapped = (sel < N_SLAVES);
        to     = 1'b0;
        if (!mapped) begin
            lat = 1; exp_rd = ERR_DATA;
        end else if (w <= TIMEOUT) begin
            lat = w; exp_rd = rdata;
        end else begin
            lat = TIMEOUT; exp_rd = ERR_DATA; to = 1'b1;
        end
        if (clr && mapped) begin
            ef = 1'b0; et = 1'b0; ea = '0;
        end
        if (!mapped || to) begin
            ef = 1'b1; et = to; ea = addr;
        end
        start   = cyc;
        m_req   = {1'b1, addr, wdata, wstrb};
        err_clr = clr;
        exp_sv  = mapped ? 3'(1 << sel) : '0;
        exp_q.push_back({32'(start + lat), exp_rd});
        done = 1'b0;
        for (int c = 0; c <= TIMEOUT + 4 && !done; c++) begin
            for (int i = 0; i < N_SLAVES; i++)
                s_resp[i*RESP_W +: RESP_W] = {$urandom(), 1'($urandom_range(0, 1))};
            if (mapped)
                s_resp[sel*RESP_W +: RESP_W] = (c == w) ? {rdata, 1'b1} : {$urandom(), 1'b0};
            @(negedge clk);
            done = m_resp[0];
            @(posedge clk);
            #1;
            err_clr = 1'b0;
        end
        if (!done) begin
            check("ready_seen", 64'(done), 64'd1);
            exp_q.delete();
        end
        m_req  = '0;
        exp_sv = '0;
        s_resp = '0;
        check_err();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [ADDR_W-1:0] a;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_resp", 64'(m_resp), 64'd0);
        check("rst_s_valid", 64'(|s_req), 64'd0);
        check_err();
        rst    = 1'b0;
        mon_on = 1'b1;
        idle(1);

        // zero-wait read on slave 0
        do_txn(32'h0000_0010, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0);
        // 3-wait write on slave 1
        do_txn(32'h4000_0004, 32'hA5A5_A5A5, 4'b0011, 3, 32'h0BAD_F00D, 1'b0);
        idle(2);
        // back-to-back zero-wait on slaves 1 and 2
        do_txn(32'h4000_0100, 32'h1, 4'hF, 0, 32'h1111_1111, 1'b0);
        do_txn(32'h8000_0200, 32'h2, 4'hF, 0, 32'h2222_2222, 1'b0);
        // unmapped
        do_txn(32'hC000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
        idle(1);
        // timeout on silent slave 1, then a late ready at cycle 10 must be ignored
        do_txn(32'h4000_0008, 32'h0, 4'h0, 1000, 32'h0, 1'b0);
        idle(1);
        s_resp[1*RESP_W +: RESP_W] = {32'hCAFE_F00D, 1'b1};
        idle(1);
        s_resp = '0;
        err_clr = 1'b1;
        ef = 1'b0; et = 1'b0; ea = '0;
        idle(1);
        err_clr = 1'b0;
        check_err();

        // leave an error latched so reset has something to clear
        do_txn(32'hE000_0040, 32'h0, 4'h0, 0, 32'h0, 1'b0);

        // reset asserted in cycle 2 of a 5-wait access to slave 0
        m_req  = {1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF};
        exp_sv = 3'b001;
        idle(2);
        #2;
        rst = 1'b1;
        #1;
        check("wait_rst_m_resp", 64'(m_resp), 64'd0);
        check("wait_rst_s_valid", 64'(|mon_any_valid(s_req)), 64'd0);
        ef = 1'b0; et = 1'b0; ea = '0;
        check_err();
        m_req  = '0;
        exp_sv = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        do_txn(32'h0000_0030, 32'h5A5A_5A5A, 4'hF, 2, 32'h7777_0000, 1'b0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            a = {2'($urandom_range(0, 3)), 30'($urandom())};
            do_txn(a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, TIMEOUT + 2),
                   $urandom(), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(2);
        mon_on = 1'b0;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic logic [N_SLAVES-1:0] mon_any_valid(input logic [N_SLAVES*REQ_W-1:0] sr);
        logic [N_SLAVES-1:0] v;
        for (int i = 0; i < N_SLAVES; i++) v[i] = sr[i*REQ_W + REQ_W - 1];
        return v;
    endfunction

endmodule
